// File: rtl/tx_channel_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : tx_channel_arbiter_if
// Purpose  : Source-FIFO read side and TX-FIFO write side of the channel arbiter.
// Revision : 1.0
// ============================================================================
interface tx_channel_arbiter_if #(
    parameter int NCH = 4
);
    logic [NCH-1:0]    ch_empty;
    logic [16*NCH-1:0] ch_q;
    logic [NCH-1:0]    ch_rdrq;
    logic              out_full;
    logic [15:0]       out_data;
    logic              out_wrreq;

    modport master (
        input  ch_empty,
        input  ch_q,
        output ch_rdrq,
        input  out_full,
        output out_data,
        output out_wrreq
    );

    modport slave (
        output ch_empty,
        output ch_q,
        input  ch_rdrq,
        output out_full,
        input  out_data,
        input  out_wrreq
    );
endinterface
`default_nettype wire

// File: rtl/tx_channel_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tx_channel_arbiter
// Purpose  : Round-robin framing arbiter from NCH source FIFOs to one TX FIFO.
// Revision : 1.0
// ============================================================================
module tx_channel_arbiter #(
    parameter int NCH   = 4,
    parameter int BURST = 256
) (
    input  logic                 CLK,
    input  logic                 RST,
    tx_channel_arbiter_if.master bus,
    output logic [2:0]           grant,
    output logic                 busy,
    output logic [2:0]           state_monitor
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        HDR  = 3'd1,
        RD   = 3'd2,
        LAT  = 3'd3,
        WR   = 3'd4,
        TRL  = 3'd5
    } state_t;

    state_t         state_q, state_d;
    logic [2:0]     grant_q, grant_d;
    logic [11:0]    cnt_q, cnt_d;
    logic [15:0]    out_data_q, out_data_d;
    logic           out_wrreq_q, out_wrreq_d;
    logic [NCH-1:0] ch_rdrq_q, ch_rdrq_d;
    logic [3:0]     w_next;
    logic [15:0]    w_sel_q;

    // Walk offsets downward so the nearest channel after the last grant wins.
    function automatic logic [3:0] next_channel(input logic [2:0] last,
                                                input logic [NCH-1:0] empty);
        logic [3:0] res;
        int         idx;
        res = {1'b0, last};
        for (int i = NCH; i >= 1; i--) begin
            idx = (int'(last) + i) % NCH;
            if (!empty[idx]) res = {1'b1, 3'(idx)};
        end
        return res;
    endfunction

    assign w_next  = next_channel(grant_q, bus.ch_empty);
    assign w_sel_q = bus.ch_q[16*int'(grant_q) +: 16];

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        cnt_d       = cnt_q;
        out_data_d  = out_data_q;
        out_wrreq_d = 1'b0;
        ch_rdrq_d   = '0;
        case (state_q)
            IDLE: begin
                if (w_next[3]) begin
                    grant_d = w_next[2:0];
                    state_d = HDR;
                end
            end
            HDR: begin
                if (!bus.out_full) begin
                    out_data_d  = {8'hA5, 5'b0, grant_q};
                    out_wrreq_d = 1'b1;
                    cnt_d       = '0;
                    state_d     = RD;
                end
            end
            RD: begin
                if (bus.ch_empty[grant_q] || (cnt_q == 12'(BURST))) begin
                    state_d = TRL;
                end else begin
                    ch_rdrq_d[grant_q] = 1'b1;
                    state_d            = LAT;
                end
            end
            LAT: state_d = WR;
            WR: begin
                // Holding here issues no new read, so the source word stays put.
                if (!bus.out_full) begin
                    out_data_d  = w_sel_q;
                    out_wrreq_d = 1'b1;
                    cnt_d       = cnt_q + 12'd1;
                    state_d     = RD;
                end
            end
            TRL: begin
                if (!bus.out_full) begin
                    out_data_d  = {4'hE, cnt_q};
                    out_wrreq_d = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q     <= IDLE;
            grant_q     <= 3'(NCH - 1);
            cnt_q       <= '0;
            out_data_q  <= '0;
            out_wrreq_q <= 1'b0;
            ch_rdrq_q   <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            cnt_q       <= cnt_d;
            out_data_q  <= out_data_d;
            out_wrreq_q <= out_wrreq_d;
            ch_rdrq_q   <= ch_rdrq_d;
        end
    end

    assign bus.out_data   = out_data_q;
    assign bus.out_wrreq  = out_wrreq_q;
    assign bus.ch_rdrq    = ch_rdrq_q;
    assign grant          = grant_q;
    assign busy           = (state_q != IDLE);
    assign state_monitor  = state_q;

endmodule
`default_nettype wire

// File: tb/tb_tx_channel_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_tx_channel_arbiter
// Purpose  : Scoreboard bench for tx_channel_arbiter with modelled source FIFOs.
// Revision : 1.0
// ============================================================================
module tb_tx_channel_arbiter;

    localparam int NCH   = 4;
    localparam int BURST = 4;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic [2:0] grant;
    logic       busy;
    logic [2:0] state_monitor;

    tx_channel_arbiter_if #(.NCH(NCH)) bus ();

    tx_channel_arbiter #(.NCH(NCH), .BURST(BURST)) dut (
        .CLK           (CLK),
        .RST           (RST),
        .bus           (bus.master),
        .grant         (grant),
        .busy          (busy),
        .state_monitor (state_monitor)
    );

    always #5 CLK = ~CLK;

    int          vectors     = 0;
    int          miscompares = 0;
    logic [15:0] exp_q [$];
    int          rd_cnt [NCH];

    // Non-show-ahead source FIFOs: a pop on one edge presents data after it.
    logic [15:0]       src [NCH][$];
    logic [16*NCH-1:0] src_q_r     = '0;
    logic [NCH-1:0]    src_empty_r = '1;
    logic              out_full    = 1'b0;

    assign bus.ch_q     = src_q_r;
    assign bus.ch_empty = src_empty_r;
    assign bus.out_full = out_full;

    always @(posedge CLK) begin
        for (int i = 0; i < NCH; i++) begin
            if (bus.ch_rdrq[i] && (src[i].size() > 0))
                src_q_r[16*i +: 16] <= src[i].pop_front();
            src_empty_r[i] <= (src[i].size() == 0);
        end
    end

    logic           prev_wrreq = 1'b0;
    logic [NCH-1:0] prev_rdrq  = '0;

    always @(negedge CLK) begin
        if (bus.out_wrreq) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL out_word: got %h, nothing expected", bus.out_data);
            end else begin
                logic [15:0] e;
                e = exp_q.pop_front();
                if (bus.out_data !== e) begin
                    miscompares++;
                    $display("FAIL out_word: got %h expected %h", bus.out_data, e);
                end
            end
        end
        if (bus.out_wrreq && prev_wrreq) begin
            miscompares++;
            $display("FAIL wrreq_spacing: got back-to-back out_wrreq expected isolated pulse");
        end
        for (int i = 0; i < NCH; i++) begin
            if (bus.ch_rdrq[i]) rd_cnt[i]++;
            if (bus.ch_rdrq[i] && prev_rdrq[i]) begin
                miscompares++;
                $display("FAIL rdrq_width: ch%0d got 2-cycle rdrq expected 1", i);
            end
        end
        prev_wrreq = bus.out_wrreq;
        prev_rdrq  = bus.ch_rdrq;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_wrreq"}, 32'(bus.out_wrreq), 0);
        check({tag, "_data"},  32'(bus.out_data), 0);
        check({tag, "_rdrq"},  32'(bus.ch_rdrq), 0);
        check({tag, "_grant"}, 32'(grant), NCH - 1);
        check({tag, "_state"}, 32'(state_monitor), 0);
        check({tag, "_busy"},  32'(busy), 0);
    endtask

    task automatic expect_words(input logic [15:0] w []);
        foreach (w[i]) exp_q.push_back(w[i]);
    endtask

    task automatic wait_drain(input string name);
        int done;
        done = 0;
        for (int c = 0; c < 3000 && done == 0; c++) begin
            @(negedge CLK);
            if (exp_q.size() == 0 && !busy && src_empty_r == '1) done = 1;
        end
        check({name, "_drained"}, 32'(exp_q.size()), 0);
    endtask

    task automatic wait_state(input logic [2:0] st, input string name);
        int done;
        done = 0;
        for (int c = 0; c < 500 && done == 0; c++) begin
            @(negedge CLK);
            if (state_monitor == st) done = 1;
        end
        check({name, "_reached"}, 32'(done), 1);
    endtask

    task automatic clear_rd_cnt();
        for (int i = 0; i < NCH; i++) rd_cnt[i] = 0;
    endtask

    initial begin
        clear_rd_cnt();
        repeat (3) @(negedge CLK);
        check_reset_values("rst0");
        RST = 1'b1;
        @(negedge CLK);

        // Single channel: ch2 with three words.
        clear_rd_cnt();
        expect_words('{16'hA502, 16'h1111, 16'h2222, 16'h3333, 16'hE003});
        src[2].push_back(16'h1111);
        src[2].push_back(16'h2222);
        src[2].push_back(16'h3333);
        wait_drain("t1");
        check("t1_grant", 32'(grant), 2);
        check("t1_rdrq2", 32'(rd_cnt[2]), 3);

        // All channels non-empty from reset: round robin from ch0, ch0 bursts.
        RST = 1'b0;
        @(negedge CLK);
        RST = 1'b1;
        expect_words('{16'hA500, 16'h0A00, 16'h0A01, 16'h0A02, 16'h0A03, 16'hE004,
                       16'hA501, 16'h0B00, 16'hE001,
                       16'hA502, 16'h0C00, 16'hE001,
                       16'hA503, 16'h0D00, 16'hE001,
                       16'hA500, 16'h0A04, 16'hE001});
        for (int k = 0; k < 5; k++) src[0].push_back(16'h0A00 + 16'(k));
        src[1].push_back(16'h0B00);
        src[2].push_back(16'h0C00);
        src[3].push_back(16'h0D00);
        wait_drain("t2");
        check("t2_grant", 32'(grant), 0);

        // Long ch1 split into bursts, ch3 interleaved.
        clear_rd_cnt();
        expect_words('{16'hA501, 16'h1000, 16'h1001, 16'h1002, 16'h1003, 16'hE004,
                       16'hA503, 16'h3000, 16'h3001, 16'hE002,
                       16'hA501, 16'h1004, 16'h1005, 16'h1006, 16'h1007, 16'hE004,
                       16'hA501, 16'h1008, 16'h1009, 16'hE002});
        for (int k = 0; k < 10; k++) src[1].push_back(16'h1000 + 16'(k));
        src[3].push_back(16'h3000);
        src[3].push_back(16'h3001);
        wait_drain("t3");
        check("t3_rdrq1", 32'(rd_cnt[1]), 10);

        // Downstream full while a data word waits in WR.
        clear_rd_cnt();
        expect_words('{16'hA500, 16'h4000, 16'h4001, 16'h4002, 16'hE003});
        for (int k = 0; k < 3; k++) src[0].push_back(16'h4000 + 16'(k));
        wait_state(3'd4, "t4_wr");
        out_full = 1'b1;
        repeat (5) begin
            @(negedge CLK);
            check("t4_hold_wrreq", 32'(bus.out_wrreq), 0);
            check("t4_hold_rdrq", 32'(bus.ch_rdrq), 0);
        end
        out_full = 1'b0;
        wait_drain("t4");
        check("t4_rdrq0", 32'(rd_cnt[0]), 3);

        // Reset in the middle of a packet; ch0 then wins over leftover ch2.
        expect_words('{16'hA502});
        for (int k = 0; k < 3; k++) src[2].push_back(16'h5000 + 16'(k));
        wait_state(3'd4, "t5_wr");
        RST = 1'b0;
        #1;
        check_reset_values("rst_mid");
        src[0].push_back(16'h6000);
        repeat (2) @(negedge CLK);
        expect_words('{16'hA500, 16'h6000, 16'hE001,
                       16'hA502, 16'h5001, 16'h5002, 16'hE002});
        RST = 1'b1;
        wait_drain("t5");
        check("t5_grant", 32'(grant), 2);

        repeat (4) @(negedge CLK);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
